apb_ram_slave: RTL and testbench
================================

APB_RAM_SLAVE -- requirements
Module: apb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning number of 32-bit RAM words; legal values are powers of two from 4 to 1024.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, meaning wait states inserted per transfer; legal range is 0..15.
REQ-003 SHALL have port PCLK  input  1  bus clock; all state changes on the rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port PSEL  input  1  slave select.
REQ-006 SHALL have port PENABLE  input  1  access-phase indicator.
REQ-007 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port PADDR  input  32  byte address.
REQ-009 SHALL have port PWDATA  input  32  write data.
REQ-010 SHALL have port PSTRB  input  4  byte-lane write strobes; PSTRB[n] qualifies PWDATA[8n+7:8n].
REQ-011 SHALL have port PPROT  input  3  protection attributes.
REQ-012 SHALL have port PRDATA  output  32  read data, registered.
REQ-013 SHALL have port PREADY  output  1  transfer-complete, registered.
REQ-014 SHALL have port PSLVERR  output  1  error response, registered.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and READY.
REQ-016 SHALL detect a setup phase as a rising edge with PSEL=1 and PENABLE=0, in any state.
REQ-017 At a setup phase, SHALL latch PADDR, PWRITE, PWDATA, PSTRB and PPROT, and SHALL compute and latch the error flag.
REQ-018 At a setup phase, SHALL load the wait counter with WAIT_CYCLES and enter WAIT; if WAIT_CYCLES=0 it SHALL enter READY instead.
REQ-019 In WAIT, SHALL decrement the counter on each rising edge with PSEL=1 and PENABLE=1; when the counter reaches 1 it SHALL enter READY on that edge.
REQ-020 Counter width SHALL be 4 bits; the counter SHALL never underflow or wrap.
REQ-021 SHALL drive PREADY=1 only while in READY, giving exactly WAIT_CYCLES+1 access cycles per transfer.
REQ-022 On entry to READY for an error-free read, SHALL load PRDATA from RAM[latched word index]; PRDATA SHALL be 0 in every other cycle.
REQ-023 A transfer SHALL complete on the edge where PSEL=1, PENABLE=1 and PREADY=1; for an error-free write, each RAM byte with its latched strobe set SHALL update on that edge; the FSM SHALL then enter IDLE, or WAIT/READY if the same edge is a new setup phase.
REQ-024 The error flag SHALL be set when PADDR[1:0]!=0 or the word index PADDR[31:2] >= DEPTH.
REQ-025 On an error, SHALL leave RAM unchanged, return PRDATA=0, and drive PSLVERR=1 while PREADY=1; PSLVERR SHALL be 0 whenever PREADY=0.
REQ-026 A write with PSTRB=0 SHALL complete normally, leave RAM unchanged, and set PSLVERR=0.
REQ-027 PSTRB SHALL be ignored on reads.
REQ-028 If PSEL drops while in WAIT or READY, SHALL abort the transfer: enter IDLE, perform no RAM write, drive PREADY=0 on the next cycle.
REQ-029 Back-to-back transfers with no IDLE cycle between them SHALL be supported.

Reset
REQ-030 While PRESETn=0, SHALL hold the FSM in IDLE with counter=0, PREADY=0, PSLVERR=0, PRDATA=0 and the error flag cleared.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 A reset asserted mid-transfer SHALL abort the transfer with no RAM write.
REQ-033 After PRESETn deasserts, SHALL accept a setup phase on the first rising edge.

Configuration
REQ-034 With macro APB_RAM_PROT_CHECK_EN defined, a write with latched PPROT[1]=1 (non-secure) to a word index >= DEPTH/2 SHALL be treated as an error per REQ-025; reads SHALL be unaffected.
REQ-035 Without APB_RAM_PROT_CHECK_EN defined, PPROT SHALL be latched but SHALL have no effect on behaviour.

Verification
REQ-036 Scenario: WAIT_CYCLES=1; write 0xDEADBEEF to 0x10 with PSTRB=0xF, then read 0x10 -> each access phase is 2 cycles, PRDATA=0xDEADBEEF, PSLVERR=0.
REQ-037 Scenario: RAM[1]=0x11223344; write 0xAABBCCDD to 0x04 with PSTRB=0x5, then read 0x04 -> PRDATA=0x11BB33DD.
REQ-038 Scenario: DEPTH=64; read 0x100 and write to 0x02 -> PREADY=1 with PSLVERR=1, PRDATA=0, RAM unchanged.
REQ-039 Scenario: WAIT_CYCLES=0; three back-to-back writes to 0x0, 0x4, 0x8 with no IDLE -> each access phase is 1 cycle, all three words written.
REQ-040 Scenario: PRESETn pulsed low in WAIT during a write of 0x12345678 to 0x20 -> PREADY=0 immediately, a later read of 0x20 returns the old value.
REQ-041 Scenario: APB_RAM_PROT_CHECK_EN defined, PPROT=3'b010, write to 0x80 (DEPTH=64) -> PSLVERR=1, no write; the same write to 0x00 -> PSLVERR=0, write performed.

Source files
------------

// File: rtl/apb_ram_slave_if.sv
// ---------------------------------------------------------------------------
// apb_ram_slave_if
// APB bus bundle for the apb_ram_slave word RAM.
//
// Signals (named after the APB bus):
//   PSEL     slave select
//   PENABLE  access-phase indicator
//   PWRITE   1 = write, 0 = read
//   PADDR    32-bit byte address
//   PWDATA   32-bit write data
//   PSTRB    byte-lane write strobes, PSTRB[n] qualifies PWDATA[8n+7:8n]
//   PPROT    protection attributes
//   PRDATA   read data (slave -> master)
//   PREADY   transfer complete (slave -> master)
//   PSLVERR  error response, only meaningful while PREADY=1
//
// Modports: master drives the request side, slave drives the response side.
// ---------------------------------------------------------------------------
interface apb_ram_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_ram_slave.sv
// ---------------------------------------------------------------------------
// apb_ram_slave
// APB slave fronting a DEPTH x 32-bit RAM with byte strobes and a
// programmable number of wait states per transfer.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 4..1024)
//   WAIT_CYCLES  wait states per transfer (0..15); a transfer has
//                WAIT_CYCLES+1 access cycles
//
// Ports:
//   PCLK       bus clock, rising edge
//   PRESETn    asynchronous active-low reset
//   apb        APB bus (slave modport)
//   dbg_state  current FSM state (0 = IDLE, 1 = WAIT, 2 = READY)
//   dbg_prot   PPROT latched at the last setup phase
//
// Optional feature (macro APB_RAM_PROT_CHECK_EN): non-secure writes
// (PPROT[1]=1) to the upper half of the RAM are answered with an error.
//
// Handshake: a setup phase is any rising edge with PSEL=1, PENABLE=0, in any
// state; it restarts the FSM. A transfer completes on the edge where PSEL=1,
// PENABLE=1 and PREADY=1. Dropping PSEL in WAIT or READY aborts the transfer
// without touching the RAM. PRDATA/PSLVERR are zero whenever PREADY=0.
// ---------------------------------------------------------------------------
module apb_ram_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_ram_slave_if.slave   apb,
  output logic [1:0]       dbg_state,
  output logic [2:0]       dbg_prot
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [31:0]   mem [DEPTH];

  // Transfer context captured at the setup phase
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    strb_q;
  logic [2:0]    prot_q;
  logic          err_q;

  logic          setup;
  logic          access;
  logic [AW-1:0] addr_idx;
  logic          err_in;

  // Next values of the registered response outputs
  logic [AW-1:0] rd_idx;
  logic          rd_err;
  logic          rd_wr;
  logic          ready_d;
  logic          slverr_d;
  logic [31:0]   rdata_d;
  logic          ram_we;

  assign setup    = apb.PSEL & ~apb.PENABLE;
  assign access   = apb.PSEL &  apb.PENABLE;
  assign addr_idx = apb.PADDR[AW+1:2];

  assign dbg_state = state;
  assign dbg_prot  = prot_q;

  // Error decode on the live bus; it is only consumed at a setup phase.
  always_comb begin
    err_in = (apb.PADDR[1:0] != 2'b00) ||
             ({2'b00, apb.PADDR[31:2]} >= 32'(DEPTH));
`ifdef APB_RAM_PROT_CHECK_EN
    if (apb.PWRITE && apb.PPROT[1] &&
        ({2'b00, apb.PADDR[31:2]} >= 32'(DEPTH / 2)))
      err_in = 1'b1;
`endif
  end

  // ---------------- state register ----------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= ST_IDLE;
    else          state <= next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state;
    if (setup) begin
      next_state = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
    end else begin
      case (state)
        ST_IDLE:  next_state = ST_IDLE;
        ST_WAIT: begin
          if (!apb.PSEL)
            next_state = ST_IDLE;
          else if (apb.PENABLE && (cnt <= 4'd1))
            next_state = ST_READY;
        end
        // READY lasts one cycle: it either completes (PENABLE=1) or aborts.
        ST_READY: if (!apb.PSEL || apb.PENABLE) next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // ---------------- output logic ----------------
  // With WAIT_CYCLES=0 READY is entered on the setup edge itself, before the
  // context registers hold the new transfer, so use the live bus values then.
  always_comb begin
    rd_idx   = setup ? addr_idx   : idx_q;
    rd_err   = setup ? err_in     : err_q;
    rd_wr    = setup ? apb.PWRITE : wr_q;
    ready_d  = (next_state == ST_READY);
    slverr_d = ready_d && rd_err;
    rdata_d  = 32'd0;
    if (ready_d && !rd_wr && !rd_err)
      rdata_d = mem[rd_idx];
    ram_we   = (state == ST_READY) && access && wr_q && !err_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb.PREADY  <= 1'b0;
      apb.PSLVERR <= 1'b0;
      apb.PRDATA  <= 32'd0;
    end else begin
      apb.PREADY  <= ready_d;
      apb.PSLVERR <= slverr_d;
      apb.PRDATA  <= rdata_d;
    end
  end

  // ---------------- transfer context and wait counter ----------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt     <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      prot_q  <= 3'd0;
      err_q   <= 1'b0;
    end else if (setup) begin
      cnt     <= 4'(WAIT_CYCLES);
      idx_q   <= addr_idx;
      wr_q    <= apb.PWRITE;
      wdata_q <= apb.PWDATA;
      strb_q  <= apb.PSTRB;
      prot_q  <= apb.PPROT;
      err_q   <= err_in;
    end else if ((state == ST_WAIT) && access && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end else if (next_state == ST_IDLE) begin
      cnt <= 4'd0;
    end
  end

  // ---------------- RAM (not reset) ----------------
  always_ff @(posedge PCLK) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb_ram_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_ram_slave
// Directed bench for apb_ram_slave. Two instances share the request bus:
// dut0 (DEPTH=64, WAIT_CYCLES=1) and dut1 (DEPTH=64, WAIT_CYCLES=0); PSEL is
// routed to the instance chosen by 'cur'. The driver pushes the expected
// {access_cycles, pslverr, prdata} of each transfer into exp_q; a monitor on
// the falling edge pops and compares whenever the selected DUT shows PREADY.
// ---------------------------------------------------------------------------
module tb_apb_ram_slave;

  localparam int W = 38;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  always #5 PCLK = ~PCLK;

  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  int          cur;

  apb_ram_slave_if bus0();
  apb_ram_slave_if bus1();

  assign bus0.PSEL    = psel && (cur == 0);
  assign bus0.PENABLE = penable;
  assign bus0.PWRITE  = pwrite;
  assign bus0.PADDR   = paddr;
  assign bus0.PWDATA  = pwdata;
  assign bus0.PSTRB   = pstrb;
  assign bus0.PPROT   = pprot;

  assign bus1.PSEL    = psel && (cur == 1);
  assign bus1.PENABLE = penable;
  assign bus1.PWRITE  = pwrite;
  assign bus1.PADDR   = paddr;
  assign bus1.PWDATA  = pwdata;
  assign bus1.PSTRB   = pstrb;
  assign bus1.PPROT   = pprot;

  logic [1:0] st0, st1;
  logic [2:0] pr0, pr1;

  apb_ram_slave #(.DEPTH(64), .WAIT_CYCLES(1)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0), .dbg_state(st0), .dbg_prot(pr0)
  );

  apb_ram_slave #(.DEPTH(64), .WAIT_CYCLES(0)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus1), .dbg_state(st1), .dbg_prot(pr1)
  );

  logic        rdy_sel, err_sel;
  logic [31:0] data_sel;
  assign rdy_sel  = (cur == 1) ? bus1.PREADY  : bus0.PREADY;
  assign err_sel  = (cur == 1) ? bus1.PSLVERR : bus0.PSLVERR;
  assign data_sel = (cur == 1) ? bus1.PRDATA  : bus0.PRDATA;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int acc_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge PCLK) begin
    logic [W-1:0] e;
    if (psel && penable) acc_cnt++;
    else                 acc_cnt = 0;
    if (rdy_sel) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got PREADY=1 expected no transfer at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("prdata",        64'(data_sel), 64'(e[31:0]));
        check("pslverr",       64'(err_sel),  64'(e[32]));
        check("access_cycles", 64'(acc_cnt),  64'(e[37:33]));
      end
    end else begin
      check("idle_resp_zero", 64'({err_sel, data_sel}), 64'd0);
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input logic [31:0] exp_data, input logic exp_err);
    logic [4:0] exp_cyc;
    logic       done;
    exp_cyc = (cur == 1) ? 5'd1 : 5'd2;
    exp_q.push_back({exp_cyc, exp_err, exp_data});
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; pprot = prot;
    @(posedge PCLK); #1;
    penable = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge PCLK);
      done = rdy_sel;
      @(posedge PCLK); #1;
    end
    check("xfer_done", 64'(done), 64'd1);
    if (!done && exp_q.size() != 0) void'(exp_q.pop_back());
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    PRESETn = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    cur = 0;
    repeat (2) @(posedge PCLK);
    #1;
    check("rst_dut0_resp", 64'({bus0.PREADY, bus0.PSLVERR, bus0.PRDATA}), 64'd0);
    check("rst_dut1_resp", 64'({bus1.PREADY, bus1.PSLVERR, bus1.PRDATA}), 64'd0);
    check("rst_dut0_state", 64'(st0), 64'd0);
    check("rst_dut1_state", 64'(st1), 64'd0);
    PRESETn = 1'b1;

    // Setup phase on the very first edge after reset release
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0);

    // Byte strobes
    xfer(1, 32'h04, 32'h11223344, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(1, 32'h04, 32'hAABBCCDD, 4'h5, 3'b000, 32'h0, 1'b0);
    xfer(0, 32'h04, 32'h0, 4'hF, 3'b000, 32'h11BB33DD, 1'b0);

    // Error responses leave the RAM untouched
    xfer(1, 32'h00, 32'h01020304, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(0, 32'h100, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1);
    xfer(1, 32'h02, 32'h55555555, 4'hF, 3'b000, 32'h0, 1'b1);
    xfer(0, 32'h8000_0010, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1);
    xfer(0, 32'h00, 32'h0, 4'h0, 3'b000, 32'h01020304, 1'b0);

    // Last legal word
    xfer(1, 32'hFC, 32'hFEEDFACE, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(0, 32'hFC, 32'h0, 4'h0, 3'b000, 32'hFEEDFACE, 1'b0);

    // Zero strobes: normal completion, no change
    xfer(1, 32'h10, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0);
    xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0);
    idle(1);

    // Abort by dropping PSEL in WAIT
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h99999999; pstrb = 4'hF; pprot = 3'b000;
    @(posedge PCLK); #1;
    check("abort_in_wait", 64'(st0), 64'd1);
    check("abort_latched_prot", 64'(pr0), 64'd0);
    psel = 1'b0;
    @(posedge PCLK); #1;
    check("abort_state_idle", 64'(st0), 64'd0);
    check("abort_pready", 64'(bus0.PREADY), 64'd0);
    xfer(0, 32'h10, 32'h0, 4'h0, 3'b000, 32'hDEADBEEF, 1'b0);

    // Reset pulse in WAIT during a write
    xfer(1, 32'h20, 32'hCAFEF00D, 4'hF, 3'b000, 32'h0, 1'b0);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20;
    pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    check("rst_mid_in_wait", 64'(st0), 64'd1);
    #2;
    PRESETn = 1'b0;
    #1;
    check("rst_mid_pready", 64'(bus0.PREADY), 64'd0);
    check("rst_mid_state", 64'(st0), 64'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    xfer(0, 32'h20, 32'h0, 4'h0, 3'b000, 32'hCAFEF00D, 1'b0);

    // Non-secure write to the upper half
    xfer(1, 32'h80, 32'h66666666, 4'hF, 3'b000, 32'h0, 1'b0);
`ifdef APB_RAM_PROT_CHECK_EN
    xfer(1, 32'h80, 32'h77777777, 4'hF, 3'b010, 32'h0, 1'b1);
    xfer(0, 32'h80, 32'h0, 4'h0, 3'b010, 32'h66666666, 1'b0);
`else
    xfer(1, 32'h80, 32'h77777777, 4'hF, 3'b010, 32'h0, 1'b0);
    xfer(0, 32'h80, 32'h0, 4'h0, 3'b010, 32'h77777777, 1'b0);
`endif
    xfer(1, 32'h00, 32'h5A5A5A5A, 4'hF, 3'b010, 32'h0, 1'b0);
    xfer(0, 32'h00, 32'h0, 4'h0, 3'b010, 32'h5A5A5A5A, 1'b0);
    idle(2);

    // Zero wait states, back-to-back on dut1
    cur = 1;
    xfer(1, 32'h0, 32'hA0A0A0A0, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(1, 32'h4, 32'hB1B1B1B1, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(1, 32'h8, 32'hC2C2C2C2, 4'hF, 3'b000, 32'h0, 1'b0);
    xfer(0, 32'h0, 32'h0, 4'h0, 3'b000, 32'hA0A0A0A0, 1'b0);
    xfer(0, 32'h4, 32'h0, 4'h0, 3'b000, 32'hB1B1B1B1, 1'b0);
    xfer(0, 32'h8, 32'h0, 4'h0, 3'b000, 32'hC2C2C2C2, 1'b0);
    xfer(0, 32'h102, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1);
    idle(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
